// File: rtl/camera.sv
// Synthetic camera frame source: streams one RGB frame as bus-wide beats of packed
// 24-bit points through a request / in-progress / data-valid handshake.
module camera #(
  parameter int BUS_WIDTH      = 96,
  parameter int FRAME_H        = 480,
  parameter int FRAME_W        = 848,
  parameter int RESPONSE_DELAY = 2
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 recieve_ready,
  output logic                 in_progress,
  output logic [BUS_WIDTH-1:0] data,
  output logic                 data_valid,
  output logic                 frame_end
);

  localparam int N_PTS = BUS_WIDTH / 24;
  localparam int ROW_W = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;
  localparam int COL_W = $clog2(FRAME_W + N_PTS);
  localparam int DLY_W = $clog2(RESPONSE_DELAY + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ROW_W-1:0] row;
  logic [COL_W-1:0] col;
  logic [DLY_W-1:0] dly_cnt;
  logic             row_last_col;
  logic             last_beat;
  logic             dly_done;

  // Point (r,c) = {(r+c) mod 256, r mod 256, c mod 256}; point 0 sits in the low bits.
  function automatic logic [BUS_WIDTH-1:0] beat_of(input logic [ROW_W-1:0] r,
                                                   input logic [COL_W-1:0] c);
    logic [BUS_WIDTH-1:0] b;
    logic [31:0]          rw;
    logic [31:0]          cw;
    logic [7:0]           r8;
    logic [7:0]           c8;
    b  = '0;
    rw = 32'(r);
    cw = 32'(c);
    r8 = rw[7:0];
    for (int k = 0; k < N_PTS; k++) begin
      c8 = cw[7:0] + 8'(k);
      b[24*k +: 24] = {8'(r8 + c8), r8, c8};
    end
    return b;
  endfunction

  assign row_last_col = (col == COL_W'(FRAME_W - N_PTS));
  assign last_beat    = row_last_col && (row == ROW_W'(FRAME_H - 1));
  assign dly_done     = (dly_cnt == DLY_W'(RESPONSE_DELAY - 1));

  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    in_progress = 1'b0;
    data_valid  = 1'b0;
    frame_end   = 1'b0;
    case (state)
      IDLE: begin
        if (recieve_ready) state_nxt = BUSY;
      end
      BUSY: begin
        in_progress = 1'b1;
        if (dly_done) state_nxt = VALID;
      end
      VALID: begin
        in_progress = 1'b1;
        data_valid  = 1'b1;
        state_nxt   = last_beat ? DONE : IDLE;
      end
      DONE: begin
        frame_end = 1'b1;
        if (recieve_ready) state_nxt = BUSY;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Beat data is latched on the BUSY->VALID edge so it is stable for the whole VALID cycle
  // and then held until the next beat; position advances as VALID retires.
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      row     <= '0;
      col     <= '0;
      dly_cnt <= '0;
      data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          dly_cnt <= '0;
        end
        BUSY: begin
          if (dly_done) begin
            data <= beat_of(row, col);
          end else begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end
        end
        VALID: begin
          dly_cnt <= '0;
          if (last_beat) begin
            row <= '0;
            col <= '0;
          end else if (row_last_col) begin
            row <= row + ROW_W'(1);
            col <= '0;
          end else begin
            col <= col + COL_W'(N_PTS);
          end
        end
        DONE: begin
          dly_cnt <= '0;
          if (recieve_ready) begin
            row <= '0;
            col <= '0;
          end
        end
        default: dly_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_camera.sv
// Directed bench for camera: default-size instance for pattern/handshake checks and a
// 2x8 instance for frame-end and asynchronous-reset sequences.
module tb_camera;

  logic        clk = 1'b0;
  logic        sys_rst_a, sys_rst_b;
  logic        rr_a, rr_b;
  logic        ip_a, ip_b;
  logic        dv_a, dv_b;
  logic        fe_a, fe_b;
  logic [95:0] data_a, data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  camera #(.BUS_WIDTH(96), .FRAME_H(480), .FRAME_W(848), .RESPONSE_DELAY(2)) dut_a (
    .clk(clk), .sys_rst(sys_rst_a), .recieve_ready(rr_a), .in_progress(ip_a),
    .data(data_a), .data_valid(dv_a), .frame_end(fe_a)
  );

  camera #(.BUS_WIDTH(96), .FRAME_H(2), .FRAME_W(8), .RESPONSE_DELAY(2)) dut_b (
    .clk(clk), .sys_rst(sys_rst_b), .recieve_ready(rr_b), .in_progress(ip_b),
    .data(data_b), .data_valid(dv_b), .frame_end(fe_b)
  );

  typedef struct {
    int          idx;
    logic [95:0] exp_data;
    int          exp_cyc;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive recieve_ready and wait (bounded) for the next data_valid pulse of one instance.
  // cycles = negedges waited until the pulse, -1 on timeout.
  task automatic next_beat(input int which, input logic rr_val,
                           output logic [95:0] d, output int cycles);
    bit got;
    got    = 1'b0;
    d      = '0;
    cycles = -1;
    if (which == 0) rr_a = rr_val; else rr_b = rr_val;
    for (int i = 1; i <= 20 && !got; i++) begin
      @(negedge clk);
      if (which == 0 ? dv_a : dv_b) begin
        got    = 1'b1;
        d      = (which == 0) ? data_a : data_b;
        cycles = i;
      end
    end
  endtask

  initial begin
    logic [95:0] d;
    int          cyc;
    int          nb;
    int          pulses;
    logic        ip_exp[4];
    logic        dv_exp[4];

    vecs[0] = '{1,   96'h070007_060006_050005_040004, 3};
    vecs[1] = '{63,  96'hFF00FF_FE00FE_FD00FD_FC00FC, 4};
    vecs[2] = '{64,  96'h030003_020002_010001_000000, 4};
    vecs[3] = '{211, 96'h4F004F_4E004E_4D004D_4C004C, 4};
    vecs[4] = '{212, 96'h040103_030102_020101_010100, 4};
    vecs[5] = '{213, 96'h080107_070106_060105_050104, 4};
    vecs[6] = '{424, 96'h050203_040202_030201_020200, 4};
    ip_exp = '{1'b1, 1'b1, 1'b1, 1'b0};
    dv_exp = '{1'b0, 1'b0, 1'b1, 1'b0};

    sys_rst_a = 1'b0;
    sys_rst_b = 1'b0;
    rr_a      = 1'b1;
    rr_b      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_progress", 96'(ip_a), 96'd0);
    check("rst_data_valid",  96'(dv_a), 96'd0);
    check("rst_frame_end",   96'(fe_a), 96'd0);
    check("rst_data",        data_a,    96'd0);

    sys_rst_a = 1'b1;
    sys_rst_b = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("first_ip_c%0d", i + 1), 96'(ip_a), 96'(ip_exp[i]));
      check($sformatf("first_dv_c%0d", i + 1), 96'(dv_a), 96'(dv_exp[i]));
      if (i >= 2) check($sformatf("first_data_c%0d", i + 1), data_a,
                        96'h030003_020002_010001_000000);
    end

    nb = 1;
    for (int v = 0; v < 7; v++) begin
      while (nb <= vecs[v].idx) begin
        next_beat(0, 1'b1, d, cyc);
        nb++;
      end
      check($sformatf("beat%0d_data", vecs[v].idx), d, vecs[v].exp_data);
      check($sformatf("beat%0d_period", vecs[v].idx), 96'(cyc), 96'(vecs[v].exp_cyc));
    end

    // recieve_ready low in IDLE starts nothing; dropping it during BUSY does not abort.
    rr_a = 1'b0;
    pulses = 0;
    repeat (4) begin
      @(negedge clk);
      if (dv_a || ip_a) pulses++;
    end
    check("idle_no_request", 96'(pulses), 96'd0);
    rr_a = 1'b1;
    @(negedge clk);
    check("busy_after_req", 96'(ip_a), 96'd1);
    next_beat(0, 1'b0, d, cyc);
    check("rr_drop_data", d, 96'h090207_080206_070205_060204);
    check("rr_drop_latency", 96'(cyc), 96'd2);

    // Small frame: 4 beats then frame_end.
    next_beat(1, 1'b1, d, cyc);
    check("sm_b0_data", d, 96'h030003_020002_010001_000000);
    check("sm_b0_period", 96'(cyc), 96'd3);
    next_beat(1, 1'b1, d, cyc);
    check("sm_b1_data", d, 96'h070007_060006_050005_040004);
    next_beat(1, 1'b1, d, cyc);
    check("sm_b2_data", d, 96'h040103_030102_020101_010100);
    next_beat(1, 1'b1, d, cyc);
    check("sm_b3_data", d, 96'h080107_070106_060105_050104);
    check("sm_b3_period", 96'(cyc), 96'd4);
    check("sm_fe_before_end", 96'(fe_b), 96'd0);
    rr_b = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("sm_fe_hold_c%0d", i), 96'(fe_b), 96'd1);
      check($sformatf("sm_no_dv_c%0d", i), 96'({dv_b, ip_b}), 96'd0);
    end

    rr_b = 1'b1;
    @(negedge clk);
    check("sm_fe_cleared", 96'(fe_b), 96'd0);
    check("sm_restart_busy", 96'(ip_b), 96'd1);
    next_beat(1, 1'b1, d, cyc);
    check("sm_restart_data", d, 96'h030003_020002_010001_000000);
    check("sm_restart_latency", 96'(cyc), 96'd2);
    next_beat(1, 1'b1, d, cyc);
    next_beat(1, 1'b1, d, cyc);
    check("sm_f2_b2_data", d, 96'h040103_030102_020101_010100);

    // Asynchronous reset during BUSY of beat 3.
    @(negedge clk);
    @(negedge clk);
    check("sm_b3_busy", 96'(ip_b), 96'd1);
    #2;
    sys_rst_b = 1'b0;
    rr_b      = 1'b0;
    #1;
    check("async_rst_ip",   96'(ip_b), 96'd0);
    check("async_rst_dv",   96'(dv_b), 96'd0);
    check("async_rst_fe",   96'(fe_b), 96'd0);
    check("async_rst_data", data_b,    96'd0);
    @(negedge clk);
    sys_rst_b = 1'b1;
    next_beat(1, 1'b1, d, cyc);
    check("after_rst_data", d, 96'h030003_020002_010001_000000);
    check("after_rst_latency", 96'(cyc), 96'd3);
    rr_b = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/camera.md
Name: camera

Overview:
- Synthesizable camera frame source: streams one RGB image as bus-wide beats of packed 24-bit points to the preprocessing front end.
- Each beat is transferred through a request/acknowledge handshake (recieve_ready -> in_progress -> data_valid).
- Pixel content is a deterministic synthetic pattern, so downstream DDR3 write/readback can be checked exactly.
- frame_end flags that the last beat of the frame has been delivered.

Parameters:
- BUS_WIDTH, 96, data bus width in bits; must be a multiple of 24. N_PTS = BUS_WIDTH/24 points per beat.
- FRAME_H, 480, rows per frame.
- FRAME_W, 848, columns per frame; must be divisible by N_PTS.
- RESPONSE_DELAY, 2, cycles from in_progress rising to data_valid; minimum 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- sys_rst  in  1  reset, asynchronous, active-low.
- recieve_ready  in  1  consumer requests the next beat.
- in_progress  out  1  beat transfer underway.
- data  out  BUS_WIDTH  packed points; point k in bits [24k+23:24k]; point 0 is the lowest column.
- data_valid  out  1  data holds a valid beat; one-cycle pulse.
- frame_end  out  1  whole frame delivered.

Behaviour:
- Reset (sys_rst=0, asynchronous):
  - in_progress, data_valid and frame_end go to 0; data goes to 0.
  - row=0, col=0, state=IDLE.
  - A reset mid-frame or mid-beat aborts the beat; the frame restarts at pixel (0,0).
- Pixel pattern for point at (r,c), 8-bit values taken mod 256:
  - bits [23:16] = (r+c)[7:0].
  - bits [15:8] = r[7:0].
  - bits [7:0] = c[7:0].
- Beat b of a row covers columns c = b*N_PTS + k for k = 0..N_PTS-1.
- States: IDLE, BUSY, VALID, DONE.
- IDLE:
  - All outputs low except data, which holds its last value.
  - recieve_ready=1 sampled -> BUSY; in_progress=1 from the next cycle.
- BUSY:
  - in_progress=1; an internal delay counter counts RESPONSE_DELAY-1 cycles, then -> VALID.
  - recieve_ready is ignored here; the consumer may drop it at any time.
- VALID (exactly one cycle):
  - data_valid=1, in_progress=1, data = current beat.
  - col advances by N_PTS. When it reaches FRAME_W, col=0 and row increments.
  - Next state: DONE if this was the last beat (row FRAME_H-1, final column group), otherwise IDLE.
- data holds its value after VALID until the next VALID cycle.
- Latency from recieve_ready sampled high to data_valid is RESPONSE_DELAY+1 cycles.
- Back-to-back: if recieve_ready is still 1 on returning to IDLE, a new beat starts immediately. Minimum beat period is RESPONSE_DELAY+2 cycles.
- DONE:
  - frame_end=1 (level, held); in_progress=0; data_valid=0.
  - recieve_ready=1 in DONE clears frame_end, resets row/col to 0 and goes to BUSY, starting the next frame.
- Beats per frame = FRAME_H*FRAME_W/N_PTS (default 101760).
- Counter widths: row is clog2(FRAME_H), col is clog2(FRAME_W+N_PTS); no overflow at the defaults.

Test Plan:
- Reset: hold sys_rst=0 with recieve_ready=1 -> all outputs 0. Release -> in_progress rises 1 cycle after recieve_ready is sampled; data_valid follows 2 cycles later (default delay).
- First beat: defaults -> data = 0x030003_020002_010001_000000 (point3..point0); data_valid high exactly 1 cycle; in_progress falls the cycle after.
- Row wrap: defaults, beat 212 (second row, col 0) -> point0 = 0x010100, point3 = 0x040103.
- Byte wrap: row 0, beat 64 (col 256) -> point0 = 0x000000, since 256 wraps to 0.
- Frame end with FRAME_H=2, FRAME_W=8:
  - Exactly 4 beats, then frame_end=1 and held; further cycles without recieve_ready produce no data_valid.
  - A new recieve_ready clears frame_end and the next data_valid returns point0 = 0x000000.
- Async reset mid-frame: assert sys_rst=0 during BUSY of beat 3 -> outputs clear immediately, with no clock edge needed; the next transfer returns the beat for row 0, col 0.
